raw_awb_gain_rgb888: RTL and testbench

- Gray-world auto-white-balance stage directly downstream of the RAW8-to-RGB888 demosaic stage.
- Consumes its vs/de/R/G/B stream and accumulates per-frame channel sums.
- During vertical blanking, computes R and B gains relative to G with a sequential divider.
- Applies the gains to the following frame with a fixed 2-cycle pipeline, so no frame ever sees a gain change mid-frame.

---
 rtl/raw_awb_gain_rgb888.sv | 229 ++++++++++++++++++++++
 tb/tb_raw_awb_gain_rgb888.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/raw_awb_gain_rgb888.sv
// raw_awb_gain_rgb888
//   Gray-world auto-white-balance stage that sits behind the RAW8->RGB888
//   demosaic. It sums R/G/B over each active frame. During vertical blanking
//   it computes the Q2.8 gains G/R and G/B with a bit-serial divider. At the
//   next frame start it commits those gains and applies them with a fixed
//   2-cycle multiply/round pipeline.
//
// Ports
//   I_clk, I_rst          pixel clock, synchronous active-high reset
//   I_awb_en              1 = apply committed gains, 0 = unity (stats keep running)
//   I_rgb_vs/de/r/g/b     input stream (vs frame valid, de pixel valid)
//   O_rgb_vs/de/r/g/b     output stream, 2-cycle latency; G is delay only
//   O_gain_r/O_gain_b     currently committed gains, Q2.8
//   O_gain_valid          sticky: at least one computed gain pair committed
module raw_awb_gain_rgb888 #(
  parameter int SUM_W    = 32,
  parameter int GAIN_MAX = 1023
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_awb_en,
  input  logic       I_rgb_vs,
  input  logic       I_rgb_de,
  input  logic [7:0] I_rgb_r,
  input  logic [7:0] I_rgb_g,
  input  logic [7:0] I_rgb_b,
  output logic       O_rgb_vs,
  output logic       O_rgb_de,
  output logic [7:0] O_rgb_r,
  output logic [7:0] O_rgb_g,
  output logic [7:0] O_rgb_b,
  output logic [9:0] O_gain_r,
  output logic [9:0] O_gain_b,
  output logic       O_gain_valid
);
  localparam logic [9:0] UNITY = 10'd256;
  localparam logic [9:0] GMAX  = 10'(GAIN_MAX);

  typedef enum logic [1:0] {ACC, CALC_R, CALC_B, DONE} state_t;
  state_t state, state_nx;

  logic             vs_d1, frame_end, vs_rise;
  logic [SUM_W-1:0] sum_r, sum_g, sum_b;
  logic [SUM_W-1:0] snap_r, snap_g, snap_b;

  // divider
  logic             busy;
  logic [3:0]       it;
  logic [SUM_W+1:0] rem;
  logic [8:0]       qacc;
  logic [SUM_W-1:0] den;
  logic [SUM_W+2:0] den4, num_w, trial, diff;
  logic             ge, is_zero, is_big, in_calc, special, div_done;
  logic [9:0]       q_full, q_clamp, div_res;
  logic [9:0]       res_r, res_b;

  // gains
  logic [9:0] pending_r, pending_b, active_r, active_b;
  logic       pending_flag, gain_valid;

  // pixel path
  logic        commit_now;
  logic [9:0]  eff_r, eff_b;
  logic [17:0] p_r, p_b;
  logic [7:0]  g1;
  logic [2:1]  vs_pipe, de_pipe;

  assign frame_end = vs_d1 & ~I_rgb_vs;
  assign vs_rise   = I_rgb_vs & ~vs_d1;

  // Restoring division of sum_g*256 by den, scaled so the remainder stays
  // below 4*den: each step doubles the remainder and trial-subtracts 4*den.
  // The pre-check sum_g < 4*den keeps the quotient within 10 bits.
  always_comb begin
    in_calc  = (state == CALC_R) || (state == CALC_B);
    den      = (state == CALC_R) ? snap_r : snap_b;
    den4     = {1'b0, den, 2'b00};
    num_w    = {3'b000, snap_g};
    trial    = {rem, 1'b0};
    diff     = trial - den4;
    ge       = trial >= den4;
    is_zero  = den == '0;
    is_big   = num_w >= den4;
    special  = in_calc && !busy && (is_zero || is_big);
    q_full   = {qacc, ge};
    q_clamp  = (q_full > GMAX) ? GMAX : q_full;
    div_res  = special ? (is_zero ? UNITY : GMAX) : q_clamp;
    div_done = special || (in_calc && busy && it == 4'd0);
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= ACC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACC:     if (frame_end) state_nx = CALC_R;
      CALC_R:  if (div_done)  state_nx = CALC_B;
      CALC_B:  if (div_done)  state_nx = DONE;
      default: state_nx = ACC;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      vs_d1        <= 1'b0;
      sum_r        <= '0;
      sum_g        <= '0;
      sum_b        <= '0;
      snap_r       <= '0;
      snap_g       <= '0;
      snap_b       <= '0;
      busy         <= 1'b0;
      it           <= '0;
      rem          <= '0;
      qacc         <= '0;
      res_r        <= UNITY;
      res_b        <= UNITY;
      pending_r    <= UNITY;
      pending_b    <= UNITY;
      pending_flag <= 1'b0;
      active_r     <= UNITY;
      active_b     <= UNITY;
      gain_valid   <= 1'b0;
    end else begin
      vs_d1 <= I_rgb_vs;

      // A frame end always restarts the statistics, even when the divider
      // is still busy and the edge itself is otherwise ignored.
      if (frame_end) begin
        sum_r <= '0;
        sum_g <= '0;
        sum_b <= '0;
      end else if (I_rgb_vs && I_rgb_de) begin
        sum_r <= sum_r + SUM_W'(I_rgb_r);
        sum_g <= sum_g + SUM_W'(I_rgb_g);
        sum_b <= sum_b + SUM_W'(I_rgb_b);
      end

      if (state == ACC && frame_end) begin
        snap_r <= sum_r;
        snap_g <= sum_g;
        snap_b <= sum_b;
      end

      if (in_calc) begin
        if (!busy) begin
          if (!(is_zero || is_big)) begin
            busy <= 1'b1;
            rem  <= {2'b00, snap_g};
            it   <= 4'd9;
            qacc <= '0;
          end
        end else begin
          rem  <= ge ? diff[SUM_W+1:0] : trial[SUM_W+1:0];
          qacc <= q_full[8:0];
          it   <= it - 4'd1;
          if (it == 4'd0) busy <= 1'b0;
        end
      end

      if (state == CALC_R && div_done) res_r <= div_res;
      if (state == CALC_B && div_done) res_b <= div_res;

      if (commit_now) begin
        active_r     <= pending_r;
        active_b     <= pending_b;
        pending_flag <= 1'b0;
        gain_valid   <= 1'b1;
      end

      // DONE comes after the commit so a fresh result is never lost.
      if (state == DONE) begin
        pending_r    <= res_r;
        pending_b    <= res_b;
        pending_flag <= 1'b1;
      end
    end
  end

  // The commit edge is also the first cycle of the new frame. Bypass the
  // pending gains so a pixel on that very cycle already sees them.
  always_comb begin
    commit_now = vs_rise && pending_flag;
    eff_r      = UNITY;
    eff_b      = UNITY;
    if (I_awb_en) begin
      eff_r = commit_now ? pending_r : active_r;
      eff_b = commit_now ? pending_b : active_b;
    end
  end

  function automatic logic [7:0] round_sat(input logic [17:0] p);
    logic [17:0] t;
    t = p + 18'd128;
    return (t[17:16] != 2'b00) ? 8'hFF : t[15:8];
  endfunction

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      p_r      <= '0;
      p_b      <= '0;
      g1       <= '0;
      vs_pipe  <= '0;
      de_pipe  <= '0;
      O_rgb_r  <= '0;
      O_rgb_g  <= '0;
      O_rgb_b  <= '0;
    end else begin
      p_r      <= 18'(I_rgb_r) * 18'(eff_r);
      p_b      <= 18'(I_rgb_b) * 18'(eff_b);
      g1       <= I_rgb_g;
      vs_pipe  <= {vs_pipe[1], I_rgb_vs};
      de_pipe  <= {de_pipe[1], I_rgb_de};
      O_rgb_r  <= round_sat(p_r);
      O_rgb_g  <= g1;
      O_rgb_b  <= round_sat(p_b);
    end
  end

  assign O_rgb_vs     = vs_pipe[2];
  assign O_rgb_de     = de_pipe[2];
  assign O_gain_r     = active_r;
  assign O_gain_b     = active_b;
  assign O_gain_valid = gain_valid;

endmodule

// File: tb/tb_raw_awb_gain_rgb888.sv
// Testbench for raw_awb_gain_rgb888: randomized frames checked cycle by cycle
// against a frame-level gray-world model (sums, gain formula, commit at frame
// start, 2-cycle output delay).
module tb_raw_awb_gain_rgb888;
  logic       I_clk = 1'b0;
  logic       I_rst, I_awb_en, I_rgb_vs, I_rgb_de;
  logic [7:0] I_rgb_r, I_rgb_g, I_rgb_b;
  logic       O_rgb_vs, O_rgb_de, O_gain_valid;
  logic [7:0] O_rgb_r, O_rgb_g, O_rgb_b;
  logic [9:0] O_gain_r, O_gain_b;

  raw_awb_gain_rgb888 dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_awb_en(I_awb_en),
    .I_rgb_vs(I_rgb_vs), .I_rgb_de(I_rgb_de),
    .I_rgb_r(I_rgb_r), .I_rgb_g(I_rgb_g), .I_rgb_b(I_rgb_b),
    .O_rgb_vs(O_rgb_vs), .O_rgb_de(O_rgb_de),
    .O_rgb_r(O_rgb_r), .O_rgb_g(O_rgb_g), .O_rgb_b(O_rgb_b),
    .O_gain_r(O_gain_r), .O_gain_b(O_gain_b), .O_gain_valid(O_gain_valid)
  );

  always #5 I_clk = ~I_clk;

  int n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model state ----
  int     act_r, act_b, m_valid;
  int     pend_r, pend_b, pflag;
  int     inf_r, inf_b, inflight, inf_ready;
  longint sr, sg, sb;
  int     prev_vs, cur_long;
  int     d1_vs, d1_de, d1_r, d1_g, d1_b;

  function automatic int gain_of(input longint g, input longint d);
    longint q;
    if (d == 0) return 256;
    q = (g * 256) / d;
    return (q > 1023) ? 1023 : int'(q);
  endfunction

  function automatic bit is_special(input longint g, input longint d);
    return (d == 0) || (g >= 4 * d);
  endfunction

  function automatic int apply(input int p, input int g);
    int v;
    v = (p * g + 128) / 256;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    act_r = 256; act_b = 256; m_valid = 0;
    pend_r = 256; pend_b = 256; pflag = 0;
    inflight = 0; inf_ready = 0; inf_r = 256; inf_b = 256;
    sr = 0; sg = 0; sb = 0; prev_vs = 0;
    d1_vs = 0; d1_de = 0; d1_r = 0; d1_g = 0; d1_b = 0;
  endtask

  // Frame start: a calculation that finished during blanking is committed
  // now; one still running finishes during this frame and waits for the next.
  task automatic m_rise();
    if (inflight && inf_ready) begin
      pend_r = inf_r; pend_b = inf_b; pflag = 1; inflight = 0;
    end
    if (pflag) begin
      act_r = pend_r; act_b = pend_b; pflag = 0; m_valid = 1;
    end
    if (inflight) begin
      pend_r = inf_r; pend_b = inf_b; pflag = 1; inflight = 0;
    end
  endtask

  task automatic m_frame_end();
    if (!inflight) begin
      inf_r = gain_of(sg, sr);
      inf_b = gain_of(sg, sb);
      inflight = 1;
      inf_ready = cur_long;
    end
    sr = 0; sg = 0; sb = 0;
  endtask

  task automatic step(input bit rst, input bit vs, input bit de,
                      input int r, input int g, input int b, input bit en);
    int e_vs, e_de, e_r, e_g, e_b;
    I_rst = rst; I_rgb_vs = vs; I_rgb_de = de; I_awb_en = en;
    I_rgb_r = 8'(r); I_rgb_g = 8'(g); I_rgb_b = 8'(b);
    e_vs = 0; e_de = 0; e_r = 0; e_g = 0; e_b = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (vs && !prev_vs) m_rise();
      if (!vs && prev_vs) m_frame_end();
      if (vs && de) begin sr += r; sg += g; sb += b; end
      prev_vs = vs;
      e_vs = vs; e_de = de; e_g = g;
      e_r = apply(r, en ? act_r : 256);
      e_b = apply(b, en ? act_b : 256);
    end
    @(posedge I_clk);
    #1;
    chk("vs",    O_rgb_vs, rst ? 0 : d1_vs);
    chk("de",    O_rgb_de, rst ? 0 : d1_de);
    chk("r",     O_rgb_r,  rst ? 0 : d1_r);
    chk("g",     O_rgb_g,  rst ? 0 : d1_g);
    chk("b",     O_rgb_b,  rst ? 0 : d1_b);
    chk("gain_r", O_gain_r, act_r);
    chk("gain_b", O_gain_b, act_b);
    chk("valid", O_gain_valid, m_valid);
    d1_vs = e_vs; d1_de = e_de; d1_r = e_r; d1_g = e_g; d1_b = e_b;
  endtask

  // 0 gray100, 1 (64,128,255), 2 (200,200,200), 3 R=0, 4 (16,128,128), 5 random
  task automatic pix(input int mode, input int rmax, output int r, output int g, output int b);
    case (mode)
      0: begin r = 100; g = 100; b = 100; end
      1: begin r = 64;  g = 128; b = 255; end
      2: begin r = 200; g = 200; b = 200; end
      3: begin r = 0; g = $urandom_range(1, 255); b = $urandom_range(1, 255); end
      4: begin r = 16;  g = 128; b = 128; end
      default: begin
        r = $urandom_range(0, rmax); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
      end
    endcase
  endtask

  function automatic bit en_of(input int enm);
    if (enm == 0) return 1'b1;
    if (enm == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic frame(input int mode, input int w, input int h, input int blank, input int enm);
    int r, g, b, rmax, nb;
    rmax = $urandom_range(16, 255);
    for (int i = 0; i < 2; i++) step(0, 1, 0, $urandom_range(0, 255), 7, $urandom_range(0, 255), en_of(enm));
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        pix(mode, rmax, r, g, b);
        step(0, 1, 1, r, g, b, en_of(enm));
      end
      for (int x = 0; x < 3; x++) step(0, 1, 0, $urandom_range(0, 255), 9, $urandom_range(0, 255), en_of(enm));
    end
    // Short blanking is only legal when the division is known to need its
    // full iterations for both channels (then it cannot finish in 10 cycles).
    cur_long = (blank >= 30) || is_special(sg, sr) || is_special(sg, sb);
    nb = (cur_long && blank < 30) ? 35 : blank;
    for (int i = 0; i < nb; i++)
      step(0, 0, ($urandom_range(0, 3) == 0), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), en_of(enm));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cur_long = 1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1);

    frame(0, 8, 4, 35, 0);
    frame(0, 8, 4, 35, 0);
    chk("gray_gain_r", O_gain_r, 256);
    chk("gray_gain_b", O_gain_b, 256);
    chk("gray_valid", O_gain_valid, 1);

    frame(1, 8, 4, 35, 0);
    frame(1, 8, 4, 35, 0);
    chk("cast_gain_r", O_gain_r, 512);
    chk("cast_gain_b", O_gain_b, 128);
    frame(2, 8, 4, 35, 0);                 // R saturates under gain 512

    frame(3, 8, 4, 35, 0);
    frame(4, 8, 4, 35, 0);
    chk("zero_r_gain", O_gain_r, 256);
    frame(0, 8, 4, 35, 0);
    chk("gmax_gain", O_gain_r, 1023);

    frame(1, 8, 4, 10, 0);                 // N: gray gains commit, 512/128 computed late
    frame(1, 8, 4, 35, 0);                 // N+1 keeps 256
    chk("late_keep_r", O_gain_r, 256);
    chk("late_keep_b", O_gain_b, 256);
    frame(1, 8, 4, 35, 0);                 // N+2 commits 512/128
    chk("late_commit_r", O_gain_r, 512);
    chk("late_commit_b", O_gain_b, 128);
    frame(1, 8, 4, 35, 1);                 // awb off: unity output
    chk("awb_off_gain_r", O_gain_r, 512);
    frame(5, 10, 5, 35, 2);                // en toggling per pixel

    // reset in the middle of a frame
    for (int i = 0; i < 2; i++) step(0, 1, 0, 1, 2, 3, 1);
    for (int x = 0; x < 12; x++) step(0, 1, 1, 16, 128, 128, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1);
    chk("rst_gain_r", O_gain_r, 256);
    chk("rst_gain_b", O_gain_b, 256);
    chk("rst_valid", O_gain_valid, 0);
    chk("rst_rgb_r", O_rgb_r, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 50, 60, 70, 1);
    frame(1, 8, 4, 35, 0);
    frame(0, 8, 4, 35, 0);
    chk("post_rst_gain_r", O_gain_r, 512);
    chk("post_rst_gain_b", O_gain_b, 128);

    for (int f = 0; f < 14; f++)
      frame($urandom_range(0, 5), $urandom_range(6, 12), $urandom_range(3, 5),
            ($urandom_range(0, 1) == 1) ? 10 : 35, $urandom_range(0, 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
